// File: rtl/usb_ep_tx_rd_pkg.sv
// usb_ep_tx_rd_pkg
//   Shared definitions for the endpoint-buffer TX read path: FSM state
//   encodings, the bytes-per-word constant, and a helper that gives the
//   number of payload bytes carried by the final word of a transfer.
package usb_ep_tx_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tx_rd_state_e;

    localparam int BYTES_PER_WORD = 4;

    // Bytes in the final word given len[1:0]: a multiple of 4 means a full word.
    function automatic logic [2:0] last_word_bytes(input logic [1:0] len_lsb);
        return (len_lsb == 2'd0) ? 3'(BYTES_PER_WORD) : {1'b0, len_lsb};
    endfunction

endpackage

// File: rtl/usb_ep_word_fifo.sv
// usb_ep_word_fifo
//   Two-entry 32-bit word FIFO. Every entry carries the number of valid
//   bytes it holds (1..4). The head entry is presented one byte at a time,
//   LSB byte first, through a byte-lane pointer; an entry is retired when
//   its last valid byte is popped, so unused lanes of a short final word
//   are never presented.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             drop all entries and reset the lane pointer
//   wr_en/wr_data/wr_cnt  capture a word and its valid-byte count
//   pop               consume the byte currently presented
//   rd_valid/rd_byte  head byte and its valid flag
//   occ               number of entries held (0..2)
module usb_ep_word_fifo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [2:0]  wr_cnt,
    input  logic        pop,
    output logic        rd_valid,
    output logic [7:0]  rd_byte,
    output logic [1:0]  occ
);

    logic [31:0] mem_q [2];
    logic [31:0] mem_d [2];
    logic [2:0]  cnt_q [2];
    logic [2:0]  cnt_d [2];
    logic        wptr_q, wptr_d;
    logic        rptr_q, rptr_d;
    logic [1:0]  occ_q, occ_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] head_word;
    logic        do_pop;
    logic        word_done;

    assign head_word = mem_q[rptr_q];
    assign rd_valid  = (occ_q != 2'd0);
    assign rd_byte   = head_word[{lane_q, 3'b000} +: 8];
    assign occ       = occ_q;

    always_comb begin
        mem_d     = mem_q;
        cnt_d     = cnt_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        occ_d     = occ_q;
        lane_d    = lane_q;
        do_pop    = pop && (occ_q != 2'd0);
        word_done = (({1'b0, lane_q} + 3'd1) == cnt_q[rptr_q]);
        if (flush) begin
            wptr_d = 1'b0;
            rptr_d = 1'b0;
            occ_d  = 2'd0;
            lane_d = 2'd0;
        end else begin
            if (do_pop) begin
                if (word_done) begin
                    rptr_d = ~rptr_q;
                    lane_d = 2'd0;
                end else begin
                    lane_d = lane_q + 2'd1;
                end
            end
            if (wr_en) begin
                mem_d[wptr_q] = wr_data;
                cnt_d[wptr_q] = wr_cnt;
                wptr_d        = ~wptr_q;
            end
            occ_d = occ_q + {1'b0, wr_en} - {1'b0, do_pop && word_done};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            occ_q  <= 2'd0;
            lane_q <= 2'd0;
        end else begin
            mem_q  <= mem_d;
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            lane_q <= lane_d;
        end
    end

endmodule

// File: rtl/usb_ep_tx_rd.sv
// usb_ep_tx_rd
//   Reads 32-bit words from the endpoint buffer (1-cycle read latency) and
//   streams them LSB byte first to the TX packet engine over a valid/ack
//   handshake. A start request supplies a word base address and a byte
//   length; exactly that many bytes are sent, the last one flagged, then
//   done pulses for one cycle.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   start/start_addr/start_len     transfer request (accepted only in idle)
//   abort                          cancel, highest priority
//   busy, done                     status
//   rd_addr_0, rd_en_0, rd_data_1  buffer read port
//   tx_data/tx_valid/tx_last/tx_ack  byte stream to the TX engine
module usb_ep_tx_rd
    import usb_ep_tx_rd_pkg::*;
#(
    parameter int AWIDTH = 11,
    parameter int ARW    = AWIDTH - 2,
    parameter int LWIDTH = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ARW-1:0]    start_addr,
    input  logic [LWIDTH-1:0] start_len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ARW-1:0]    rd_addr_0,
    output logic              rd_en_0,
    input  logic [31:0]       rd_data_1,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              tx_last,
    input  logic              tx_ack
);

    localparam int WW = LWIDTH - 1;   // enough for ceil((2^LWIDTH-1)/4) words
    localparam logic [ARW-1:0]    ADDR_ONE = 1;
    localparam logic [LWIDTH-1:0] LEN_ONE  = 1;
    localparam logic [WW-1:0]     WRD_ONE  = 1;

    tx_rd_state_e      state_q, state_d;
    logic [ARW-1:0]    addr_q, addr_d;        // next word to fetch
    logic [WW-1:0]     words_q, words_d;      // words still to fetch
    logic [LWIDTH-1:0] bytes_q, bytes_d;      // bytes still to be acked
    logic [2:0]        last_cnt_q, last_cnt_d;
    logic              rd_en_q, rd_en_d;
    logic [ARW-1:0]    rd_addr_q, rd_addr_d;
    logic [2:0]        rd_cnt_q, rd_cnt_d;    // byte count of the word being read
    logic              cap_q, cap_d;          // read data arrives this cycle
    logic [2:0]        cap_cnt_q, cap_cnt_d;

    logic [LWIDTH:0]   len_p3;
    logic [WW-1:0]     start_words;
    logic [2:0]        start_last;
    logic [2:0]        pending;
    logic              fifo_flush;
    logic              fifo_pop;
    logic              fifo_valid;
    logic [7:0]        fifo_byte;
    logic [1:0]        fifo_occ;

    assign len_p3      = {1'b0, start_len} + (LWIDTH+1)'(3);
    assign start_words = len_p3[LWIDTH:2];
    assign start_last  = last_word_bytes(start_len[1:0]);

    // Words held plus words on their way in; the FIFO never overfills
    // because a read is only launched while this stays below two.
    assign pending = {1'b0, fifo_occ} + {2'b0, rd_en_q} + {2'b0, cap_q};

    assign tx_valid  = fifo_valid;
    assign tx_data   = fifo_byte;
    assign tx_last   = fifo_valid && (bytes_q == LEN_ONE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign rd_en_0   = rd_en_q;
    assign rd_addr_0 = rd_addr_q;
    assign fifo_pop  = fifo_valid && tx_ack && !abort;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        words_d    = words_q;
        bytes_d    = bytes_q;
        last_cnt_d = last_cnt_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_cnt_d   = rd_cnt_q;
        cap_d      = rd_en_q;
        cap_cnt_d  = rd_cnt_q;
        fifo_flush = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bytes_d    = start_len;
                    last_cnt_d = start_last;
                    if (start_len == '0) begin
                        state_d = ST_DONE;
                        words_d = '0;
                    end else begin
                        // First read launches straight from idle to hit
                        // rd_en_0 in the cycle after start.
                        state_d   = ST_RUN;
                        rd_en_d   = 1'b1;
                        rd_addr_d = start_addr;
                        addr_d    = start_addr + ADDR_ONE;
                        words_d   = start_words - WRD_ONE;
                        rd_cnt_d  = (start_words == WRD_ONE) ? start_last : 3'(BYTES_PER_WORD);
                    end
                end
            end
            ST_RUN: begin
                if ((words_q != '0) && (pending < 3'd2)) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = addr_q;
                    addr_d    = addr_q + ADDR_ONE;
                    words_d   = words_q - WRD_ONE;
                    rd_cnt_d  = (words_q == WRD_ONE) ? last_cnt_q : 3'(BYTES_PER_WORD);
                end
                if (fifo_pop && (bytes_q != '0)) begin
                    bytes_d = bytes_q - LEN_ONE;
                    if (bytes_q == LEN_ONE) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d    = ST_IDLE;
            rd_en_d    = 1'b0;
            cap_d      = 1'b0;     // discard a read already in flight
            words_d    = '0;
            bytes_d    = '0;
            fifo_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            words_q    <= '0;
            bytes_q    <= '0;
            last_cnt_q <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_cnt_q   <= '0;
            cap_q      <= 1'b0;
            cap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            words_q    <= words_d;
            bytes_q    <= bytes_d;
            last_cnt_q <= last_cnt_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            rd_cnt_q   <= rd_cnt_d;
            cap_q      <= cap_d;
            cap_cnt_q  <= cap_cnt_d;
        end
    end

    usb_ep_word_fifo u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (fifo_flush),
        .wr_en    (cap_q && !abort),
        .wr_data  (rd_data_1),
        .wr_cnt   (cap_cnt_q),
        .pop      (fifo_pop),
        .rd_valid (fifo_valid),
        .rd_byte  (fifo_byte),
        .occ      (fifo_occ)
    );

endmodule

// File: tb/tb_usb_ep_tx_rd.sv
module tb_usb_ep_tx_rd;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [8:0]  start_addr;
    logic [10:0] start_len;
    logic        abort;
    logic        busy;
    logic        done;
    logic [8:0]  rd_addr_0;
    logic        rd_en_0;
    logic [31:0] rd_data_1;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ack;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [512];

    usb_ep_tx_rd dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .start_len(start_len), .abort(abort), .busy(busy), .done(done),
        .rd_addr_0(rd_addr_0), .rd_en_0(rd_en_0), .rd_data_1(rd_data_1),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ack(tx_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer read port: one-cycle latency.
    always @(posedge clk) if (rd_en_0) rd_data_1 <= mem[rd_addr_0];

    typedef struct {
        int addr;
        int len;
        int mode;       // 0 ack always, 1 ack toggles, 2 random ack
        int exp_reads;
        int exp_done;   // cycle of done (start cycle = 0), -1 when not fixed
        bit poke;       // pulse a second start mid-transfer
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: byte k of the payload is lane k%4 of word addr+k/4 (mod 512).
    function automatic logic [7:0] exp_byte(input int addr, input int k);
        logic [31:0] w;
        w = mem[(addr + k / 4) % 512];
        return 8'(w >> (8 * (k % 4)));
    endfunction

    task automatic run_xfer(input int addr, input int len, input int mode,
                            input int exp_reads, input int exp_done, input bit poke);
        int cyc, acc, nrd, cons, first_v, budget;
        bit got_done, prev_stall, last_acc, a;
        logic [7:0] prev_data;
        start      = 1'b1;
        start_addr = 9'(addr);
        start_len  = 11'(len);
        tx_ack     = 1'b0;
        cyc = 0; acc = 0; nrd = 0; first_v = -1;
        got_done = 0; prev_stall = 0; last_acc = 0; prev_data = '0;
        budget = 100 + len * 8;
        while (!got_done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = (poke && cyc == 5);
            if (poke && cyc == 5) begin
                start_addr = 9'(addr + 7);
                start_len  = 11'd2;
            end
            if (rd_en_0) begin
                chk("rd_addr", rd_addr_0, (addr + nrd) % 512);
                nrd++;
            end
            cons = acc / 4 + ((acc == len && (len % 4) != 0) ? 1 : 0);
            chk("buffered_le_2", (nrd - cons) <= 2, 1);
            chk("done", done, (len == 0) ? (cyc == 1) : last_acc);
            chk("busy", busy, 1);
            if (done) got_done = 1;
            if (prev_stall) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, prev_data);
            end
            case (mode)
                0:       a = 1'b1;
                1:       a = cyc[0];
                default: a = 1'($urandom_range(0, 1));
            endcase
            tx_ack   = a;
            last_acc = 0;
            if (tx_valid) begin
                if (first_v < 0) first_v = cyc;
                if (acc >= len) begin
                    chk("extra_byte", acc, len - 1);
                end else begin
                    chk("tx_data", tx_data, exp_byte(addr, acc));
                    chk("tx_last", tx_last, acc == len - 1);
                end
                if (a) begin
                    acc++;
                    if (acc == len) last_acc = 1;
                end
                prev_stall = !a;
                prev_data  = tx_data;
            end else begin
                prev_stall = 0;
            end
        end
        chk("done_seen", got_done, 1);
        chk("byte_count", acc, len);
        chk("read_count", nrd, exp_reads);
        if (exp_done >= 0) chk("done_cycle", cyc, exp_done);
        if (mode == 0 && len > 0) chk("first_valid_cycle", first_v, 3);
        tx_ack = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_valid", tx_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_addr = '0; start_len = '0;
        abort = 1'b0; tx_ack = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = $urandom;
        mem[5] = 32'h44332211;
        mem[6] = 32'h88776655;

        tbl[0] = '{addr: 5,   len: 8,  mode: 0, exp_reads: 2,  exp_done: 11, poke: 0};
        tbl[1] = '{addr: 5,   len: 5,  mode: 0, exp_reads: 2,  exp_done: 8,  poke: 0};
        tbl[2] = '{addr: 5,   len: 8,  mode: 1, exp_reads: 2,  exp_done: -1, poke: 0};
        tbl[3] = '{addr: 5,   len: 0,  mode: 0, exp_reads: 0,  exp_done: 1,  poke: 0};
        tbl[4] = '{addr: 511, len: 8,  mode: 0, exp_reads: 2,  exp_done: 11, poke: 0};
        tbl[5] = '{addr: 100, len: 1,  mode: 0, exp_reads: 1,  exp_done: 4,  poke: 0};
        tbl[6] = '{addr: 200, len: 13, mode: 2, exp_reads: 4,  exp_done: -1, poke: 0};
        tbl[7] = '{addr: 300, len: 64, mode: 0, exp_reads: 16, exp_done: 67, poke: 0};
        tbl[8] = '{addr: 5,   len: 8,  mode: 0, exp_reads: 2,  exp_done: 11, poke: 1};

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en_0, 0);
        chk("rst_rd_addr", rd_addr_0, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_last", tx_last, 0);
        chk("rst_data", tx_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_xfer(tbl[i].addr, tbl[i].len, tbl[i].mode, tbl[i].exp_reads,
                     tbl[i].exp_done, tbl[i].poke);

        // Abort after three acked bytes of an 8-byte transfer.
        start = 1'b1; start_addr = 9'd5; start_len = 11'd8; tx_ack = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);          // bytes accepted at cycles 3,4,5
        chk("abort_pre_valid", tx_valid, 1);
        abort = 1'b1; tx_ack = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", tx_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_abort_quiet", {done, tx_valid, busy, rd_en_0}, 0);
        end
        run_xfer(40, 6, 0, 2, 9, 0);

        // Abort and start together: abort wins.
        start = 1'b1; abort = 1'b1; start_addr = 9'd5; start_len = 11'd4;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", busy, 0);
        chk("abort_start_rd_en", rd_en_0, 0);
        @(negedge clk);
        chk("abort_start_done", done, 0);

        // Reset mid-stream.
        start = 1'b1; start_addr = 9'd5; start_len = 11'd8; tx_ack = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outputs", {busy, done, rd_en_0, tx_valid, tx_last, tx_data, rd_addr_0}, 0);
        tx_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_idle_busy", busy, 0);
        chk("arst_idle_done", done, 0);
        run_xfer(5, 8, 0, 2, 11, 0);

        // Random transfers against the reference.
        for (int r = 0; r < 20; r++) begin
            int ra, rl;
            ra = $urandom_range(0, 511);
            rl = $urandom_range(0, 40);
            run_xfer(ra, rl, 2, (rl + 3) / 4, -1, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
